// File: rtl/mem_block_serializer.sv
// ============================================================================
// mem_block_serializer : splits 256-bit cache block requests into 32-bit beats
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_block_serializer #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 256,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BLOCK_SIZE-1:0] mem_wr,
  input  logic                  mem_rw,
  input  logic                  mem_valid,
  output logic [BLOCK_SIZE-1:0] mem_rd,
  output logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [DATA_WIDTH-1:0] dram_wdata,
  output logic                  dram_we,
  output logic                  dram_req,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  input  logic                  dram_ack,
  output logic                  bus_err
);

  localparam int BEATS  = BLOCK_SIZE / DATA_WIDTH;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [ADDR_WIDTH-BEAT_W-1:0] base;
  logic [BLOCK_SIZE-1:0]        wblock;
  logic [BLOCK_SIZE-1:0]        rbuf;
  logic                         rw;
  logic [BEAT_W-1:0]            beat;
  logic [TO_W-1:0]              tcnt;
  logic                         last_beat;
  logic                         timed_out;
  logic                         unused_addr_lsbs;

  // Low address bits select the word inside the block and are regenerated per beat
  assign unused_addr_lsbs = ^mem_addr[BEAT_W-1:0];

  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign timed_out = (tcnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_valid) state_nxt = BEAT;
      BEAT: begin
        if (dram_ack) begin
          if (last_beat) state_nxt = RESP;
        end else if (timed_out) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base    <= '0;
      wblock  <= '0;
      rbuf    <= '0;
      rw      <= 1'b0;
      beat    <= '0;
      tcnt    <= '0;
      mem_rd  <= '0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid) begin
            base   <= mem_addr[ADDR_WIDTH-1:BEAT_W];
            wblock <= mem_wr;
            rw     <= mem_rw;
            beat   <= '0;
            tcnt   <= '0;
          end
        end
        BEAT: begin
          if (dram_ack) begin
            if (!rw) rbuf[beat*DATA_WIDTH +: DATA_WIDTH] <= dram_rdata;
            tcnt <= '0;
            if (last_beat) begin
              // Final word bypasses the assembly buffer so mem_rd is complete at RESP
              if (!rw) mem_rd <= {dram_rdata, rbuf[BLOCK_SIZE-DATA_WIDTH-1:0]};
              beat <= '0;
            end else begin
              beat <= beat + 1'b1;
            end
          end else if (timed_out) begin
            bus_err <= 1'b1;
            beat    <= '0;
            tcnt    <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dram_req   = (state == BEAT);
  assign dram_we    = rw & dram_req;
  assign dram_addr  = {base, beat};
  assign dram_wdata = wblock[beat*DATA_WIDTH +: DATA_WIDTH];
  assign mem_ready  = (state == RESP);

endmodule

`default_nettype wire

// File: tb/tb_mem_block_serializer.sv
// ============================================================================
// tb_mem_block_serializer : randomized bench with a transaction-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_block_serializer;

  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [27:0]  mem_addr;
  logic [255:0] mem_wr;
  logic         mem_rw;
  logic         mem_valid;
  logic [255:0] mem_rd;
  logic         mem_ready;
  logic [27:0]  dram_addr;
  logic [31:0]  dram_wdata;
  logic         dram_we;
  logic         dram_req;
  logic [31:0]  dram_rdata;
  logic         dram_ack;
  logic         bus_err;

  always #5 clk = ~clk;

  mem_block_serializer #(
    .ADDR_WIDTH(28), .DATA_WIDTH(32), .BLOCK_SIZE(256), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rw(mem_rw), .mem_valid(mem_valid),
    .mem_rd(mem_rd), .mem_ready(mem_ready),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
    .dram_req(dram_req), .dram_rdata(dram_rdata), .dram_ack(dram_ack),
    .bus_err(bus_err)
  );

  // Expected view of the current cycle, set right after each rising edge
  logic         exp_req, exp_we, exp_ready, exp_err;
  logic [27:0]  exp_addr;
  logic [31:0]  exp_wdata;
  logic [255:0] exp_rd;
  logic [255:0] wblk;
  logic [255:0] rblk;
  int           waits [8];
  bit           chk_en = 1'b0;
  bit           zero_chk;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("dram_req", dram_req, exp_req);
      check("mem_ready", mem_ready, exp_ready);
      check("bus_err", bus_err, exp_err);
      check("mem_rd", mem_rd, exp_rd);
      if (exp_req) begin
        check("dram_addr", dram_addr, exp_addr);
        check("dram_we", dram_we, exp_we);
        check("dram_wdata", dram_wdata, exp_wdata);
      end
      if (zero_chk) begin
        check("rst_addr", dram_addr, 28'h0);
        check("rst_wdata", dram_wdata, 32'h0);
        check("rst_we", dram_we, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit spurious);
    mem_valid = 1'b0;
    exp_req   = 1'b0;
    exp_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      dram_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      dram_rdata = $urandom;
      tick();
    end
    dram_ack = 1'b0;
  endtask

  // One block transaction; waits[k] = idle cycles before the ack of beat k
  task automatic do_block(input logic [27:0] addr, input logic rw, input bit pat,
                          input bit drop, input int abort_at, output int lat);
    bit          to;
    logic [31:0] rd;
    lat        = 0;
    to         = 1'b0;
    mem_addr   = addr;
    mem_wr     = wblk;
    mem_rw     = rw;
    mem_valid  = 1'b1;
    dram_ack   = 1'($urandom_range(0, 1));
    dram_rdata = $urandom;
    exp_req    = 1'b0;
    exp_ready  = 1'b0;
    tick();
    lat++;
    if (drop) begin
      mem_valid = 1'b0;
      mem_addr  = 28'($urandom);
      mem_rw    = ~rw;
      for (int i = 0; i < 8; i++) mem_wr[i*32 +: 32] = $urandom;
    end
    for (int k = 0; k < 8; k++) begin
      exp_req   = 1'b1;
      exp_addr  = {addr[27:3], 3'(k)};
      exp_we    = rw;
      exp_wdata = wblk[k*32 +: 32];
      if (k == abort_at) begin
        rst_n    = 1'b0;
        dram_ack = 1'b0;
        tick();
        rst_n     = 1'b1;
        mem_valid = 1'b0;
        exp_req   = 1'b0;
        exp_ready = 1'b0;
        exp_rd    = '0;
        exp_err   = 1'b0;
        zero_chk  = 1'b1;
        idle(4, 1'b0);
        zero_chk  = 1'b0;
        return;
      end
      for (int w = 0; ; w++) begin
        rd         = pat ? 32'h1000_0000 + 32'(k) : $urandom;
        dram_rdata = rd;
        dram_ack   = (w == waits[k]);
        if (w == waits[k]) begin
          if (!rw) rblk[k*32 +: 32] = rd;
          tick();
          lat++;
          break;
        end
        if (w == TO - 1) begin
          tick();
          lat++;
          to = 1'b1;
          break;
        end
        tick();
        lat++;
      end
      if (to) break;
    end
    exp_req   = 1'b0;
    exp_ready = 1'b1;
    if (to) exp_err = 1'b1;
    else if (!rw) exp_rd = rblk;
    dram_ack  = 1'($urandom_range(0, 1));
    tick();
    exp_ready = 1'b0;
    dram_ack  = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [27:0] a;
    bit          r;
    rst_n      = 1'b0;
    mem_addr   = '0;
    mem_wr     = '0;
    mem_rw     = 1'b0;
    mem_valid  = 1'b0;
    dram_rdata = '0;
    dram_ack   = 1'b0;
    exp_req    = 1'b0;
    exp_we     = 1'b0;
    exp_ready  = 1'b0;
    exp_err    = 1'b0;
    exp_addr   = '0;
    exp_wdata  = '0;
    exp_rd     = '0;
    rblk       = '0;
    wblk       = '0;
    zero_chk   = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    idle(2, 1'b0);
    zero_chk = 1'b0;

    // Read with ack tied high
    for (int k = 0; k < 8; k++) waits[k] = 0;
    do_block(28'h0000_A48, 1'b0, 1'b1, 1'b0, -1, lat);
    check("t1_latency", lat, 9);
    check("t1_word3", mem_rd[127:96], 32'h1000_0003);
    check("t1_model_word7", exp_rd[255:224], 32'h1000_0007);
    idle(2, 1'b0);

    // Write with ack every third cycle
    for (int k = 0; k < 8; k++) begin
      waits[k] = 2;
      wblk[k*32 +: 32] = 32'hDEAD_0000 | 32'(k);
    end
    do_block(28'h0123_450, 1'b1, 1'b0, 1'b0, -1, lat);
    check("t2_latency", lat, 25);
    check("t2_rd_kept", mem_rd[31:0], 32'h1000_0000);

    // Back-to-back flush writes with mem_valid held high
    for (int k = 0; k < 8; k++) waits[k] = 0;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 8; k++) wblk[k*32 +: 32] = $urandom;
      do_block(28'h0200_000 + 28'(8 * b), 1'b1, 1'b0, 1'b0, -1, lat);
      check("t3_latency", lat, 9);
    end
    idle(2, 1'b0);

    // Timeout on a read
    waits[0] = 100;
    do_block(28'h0000_100, 1'b0, 1'b0, 1'b0, -1, lat);
    check("t4_latency", lat, 5);
    check("t4_err", bus_err, 1'b1);
    check("t4_rd_kept", mem_rd[63:32], 32'h1000_0001);
    waits[0] = 0;
    do_block(28'h0000_200, 1'b0, 1'b0, 1'b0, -1, lat);
    check("t4_err_sticky", bus_err, 1'b1);
    idle(1, 1'b0);

    // Reset during beat 5 of a write, then a fresh read
    for (int k = 0; k < 8; k++) waits[k] = $urandom_range(0, 2);
    do_block(28'h0333_330, 1'b1, 1'b0, 1'b0, 5, lat);
    check("t5_err_cleared", bus_err, 1'b0);
    do_block(28'h0444_440, 1'b0, 1'b0, 1'b0, -1, lat);
    idle(1, 1'b0);

    // mem_valid dropped after acceptance, spurious acks while idle
    idle(3, 1'b1);
    do_block(28'h0555_558, 1'b0, 1'b0, 1'b1, -1, lat);
    idle(3, 1'b1);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      a = 28'($urandom);
      r = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) begin
        waits[k] = ($urandom_range(0, 19) == 0) ? 7 : $urandom_range(0, 3);
        wblk[k*32 +: 32] = $urandom;
      end
      do_block(a, r, 1'b0, 1'($urandom_range(0, 1)), -1, lat);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 1'b1);
    end
    idle(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_block_serializer.md
Name: mem_block_serializer

Overview:
Sits directly downstream of the data-cache controller on its memory port. Accepts one 256-bit block read (allocate) or write (write-back/flush) request per handshake. Splits it into eight 32-bit word beats on a narrow req/ack main-memory bus. Returns a single-cycle mem_ready pulse when the whole block is done; for reads, the assembled 256-bit block is returned with it.

Parameters:
ADDR_WIDTH, 28, width of the word address on both sides
DATA_WIDTH, 32, narrow-bus beat width
BLOCK_SIZE, 256, cache block width; BEATS = BLOCK_SIZE/DATA_WIDTH = 8
TIMEOUT, 255, maximum cycles to wait for dram_ack on one beat before aborting

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
mem_addr  in  28  block request address; bits [2:0] ignored (block-aligned)
mem_wr  in  256  write block; word k = bits [32k+31:32k]
mem_rw  in  1  1 = write block, 0 = read block
mem_valid  in  1  request valid, held by the cache until mem_ready
mem_rd  out  256  read block, valid in the mem_ready cycle of a read
mem_ready  out  1  one-cycle completion pulse
dram_addr  out  28  beat word address
dram_wdata  out  32  beat write data
dram_we  out  1  beat is a write
dram_req  out  1  beat request, held until acked
dram_rdata  in  32  beat read data, sampled with dram_ack
dram_ack  in  1  beat accepted/completed; only meaningful while dram_req = 1
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - All outputs go to 0: mem_rd, mem_ready, dram_req, dram_we, dram_addr, dram_wdata, bus_err.
  - State goes to IDLE; beat counter and timeout counter are cleared.
  - A reset mid-transaction aborts it; dram_req is low from the next cycle. No mem_ready is issued for the aborted request.
- FSM states: IDLE, BEAT, RESP.
- IDLE:
  - mem_ready = 0 and dram_req = 0.
  - If mem_valid = 1, latch mem_addr[27:3], mem_wr and mem_rw into internal registers. Set beat = 0, clear the timeout counter, go to BEAT.
- BEAT:
  - dram_req = 1.
  - dram_addr = {base[27:3], beat[2:0]}; dram_we = latched rw; dram_wdata = latched block word[beat].
  - All of these are driven from registered state and held stable until dram_ack.
  - On dram_ack = 1:
    - If read, store dram_rdata into word[beat] of the read assembly buffer.
    - If beat = 7, go to RESP. For a read, mem_rd is loaded at this same edge with the full block, including the final dram_rdata.
    - Otherwise beat increments, the timeout counter clears, and BEAT continues. Back-to-back beats need no idle cycle.
  - Without dram_ack, the timeout counter increments.
  - When the counter reaches TIMEOUT: set bus_err = 1 (sticky until reset), go to RESP, and leave mem_rd unchanged.
- RESP:
  - mem_ready = 1 for exactly one cycle; dram_req = 0.
  - Next state is always IDLE.
  - A request still presented by the cache is evaluated only in IDLE, so every block costs one bubble cycle and the same request can never be double-accepted.
- Latency: request seen in IDLE at cycle T with dram_ack tied high gives beats at T+1..T+8 and mem_ready at T+9. Each wait cycle per beat adds one cycle.
- mem_rd holds its value between reads; writes and timeouts do not modify it.
- mem_valid deasserting mid-transaction is ignored:
  - The transaction runs to completion and its mem_ready pulse is still issued.
  - The latched request is used throughout; mem_addr and mem_wr changes after acceptance have no effect.
- dram_ack while dram_req = 0 (IDLE/RESP) is ignored.
- Beat counter wraps only via the transition to RESP, never past 7.
- Timeout counter width is clog2(TIMEOUT+1); TIMEOUT = 0 is illegal.

Test Plan:
1. Read block at mem_addr = 28'h0000_A48, dram_ack tied 1, dram_rdata = 32'h1000_0000 + beat. Required response:
   - dram_addr steps 28'h0000_A48..28'h0000_A4F.
   - mem_ready pulses at T+9 with mem_rd word k = 32'h1000_000k.
   - dram_we = 0 throughout.
2. Write block at mem_addr = 28'h0123_450, mem_wr word k = 32'hDEAD_0000 | k, dram_ack asserted every 3rd cycle. Required response:
   - Eight beats, each with dram_we = 1, carrying the matching word and address.
   - dram_req held between acks; mem_ready at the 24th BEAT cycle + 1.
   - mem_rd unchanged.
3. Flush-style back-to-back writes: mem_valid held high while the address advances by 8 right after each mem_ready. Required response:
   - Each block is accepted exactly once, with one bubble cycle between blocks.
   - No beat is duplicated.
4. Timeout, TIMEOUT = 4, dram_ack held 0 on a read. Required response:
   - bus_err rises with mem_ready.
   - mem_rd keeps its prior value.
   - bus_err stays 1 through later successful transactions until rst_n = 0.
5. rst_n = 0 during beat 5 of a write. Required response:
   - The next cycle has dram_req = 0 and all outputs 0.
   - No mem_ready is issued.
   - A fresh read after reset completes normally.
6. mem_valid dropped after acceptance plus a spurious dram_ack while idle. Required response:
   - The transaction still completes with a single mem_ready.
   - The spurious ack causes no state change.
